// File: rtl/pcf8574_lcd_seq.sv
// pcf8574_lcd_seq: turns HD44780 command/data bytes into PCF8574 backpack
// port bytes (4-bit mode) and feeds them one at a time to simple_i2c.
// Runs the power-up init nibbles, settles after every byte, retries on error.
module pcf8574_lcd_seq #(
  parameter logic [6:0]  ADDR             = 7'h27,
  parameter logic        BACKLIGHT        = 1'b1,
  parameter int unsigned INIT_WAIT_CYCLES = 4_000_000,
  parameter int unsigned SETTLE_CYCLES    = 200_000,
  parameter int unsigned START_TIMEOUT    = 4,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_data,
  output logic       i2c_write_ena,
  input  logic       i2c_busy,
  input  logic       i2c_error,
  output logic       init_done,
  output logic       err_sticky
);

  localparam logic [31:0] LP_INIT_LOAD   = 32'(INIT_WAIT_CYCLES - 1);
  localparam logic [31:0] LP_SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] LP_START_LOAD  = 32'(START_TIMEOUT - 1);
  localparam logic [31:0] LP_MAX_RETRY   = 32'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_POR_WAIT,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_IDLE
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_retry;
  logic [2:0]  r_idx;
  logic        r_init;
  logic        r_rs;
  logic [7:0]  r_data;

  logic [3:0]  w_nib;
  logic        w_en;
  logic        w_rs;
  logic        w_last;

  assign i2c_addr = ADDR;

  // Select nibble/EN/RS for the current byte index and flag the final byte.
  always_comb begin
    w_en   = ~r_idx[0];
    w_nib  = 4'h3;
    w_rs   = 1'b0;
    w_last = 1'b0;
    if (r_init) begin
      w_nib  = (r_idx[2:1] == 2'd3) ? 4'h2 : 4'h3;
      w_rs   = 1'b0;
      w_last = (r_idx == 3'd7);
    end else begin
      w_nib  = r_idx[1] ? r_data[3:0] : r_data[7:4];
      w_rs   = r_rs;
      w_last = (r_idx[1:0] == 2'd3);
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_POR_WAIT;
      r_cnt         <= LP_INIT_LOAD;
      r_retry       <= '0;
      r_idx         <= '0;
      r_init        <= 1'b0;
      r_rs          <= 1'b0;
      r_data        <= '0;
      in_ready      <= 1'b0;
      i2c_write_ena <= 1'b0;
      init_done     <= 1'b0;
      err_sticky    <= 1'b0;
      i2c_data      <= {4'h0, BACKLIGHT, 3'b000};
    end else begin
      i2c_write_ena <= 1'b0;
      case (r_state)
        ST_POR_WAIT: begin
          if (r_cnt == '0) begin
            r_idx   <= '0;
            r_init  <= 1'b1;
            r_state <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        ST_LOAD: begin
          i2c_data <= {w_nib, BACKLIGHT, w_en, 1'b0, w_rs};
          r_retry  <= '0;
          r_state  <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!i2c_busy) begin
            i2c_write_ena <= 1'b1;
            r_cnt         <= LP_START_LOAD;
            r_state       <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (i2c_busy || (r_cnt == '0)) begin
            r_state <= ST_WAIT_DONE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!i2c_busy) begin
            if (i2c_error && (r_retry < LP_MAX_RETRY)) begin
              r_retry <= r_retry + 32'd1;
              r_state <= ST_ISSUE;
            end else begin
              if (i2c_error) begin
                err_sticky <= 1'b1;
              end
              r_cnt   <= LP_SETTLE_LOAD;
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            if (!w_last) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_LOAD;
            end else begin
              if (r_init) begin
                init_done <= 1'b1;
                r_init    <= 1'b0;
              end
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_rs     <= in_rs;
            r_data   <= in_data;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= ST_LOAD;
          end else begin
            in_ready <= init_done;
          end
        end
        default: r_state <= ST_POR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pcf8574_lcd_seq.sv
// Scoreboard bench for pcf8574_lcd_seq: stimulus pushes expected port bytes,
// a monitor pops them on every write pulse and checks timing around them.
module tb_pcf8574_lcd_seq;

  localparam int SETTLE    = 3;
  localparam int MAXR      = 2;
  localparam int BL        = 1;
  localparam int K_NORMAL  = 0;
  localparam int K_RETRY   = 1;
  localparam int K_UFIRST  = 2;
  localparam int K_IFIRST  = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       i2c_write_ena;
  logic       i2c_busy;
  logic       i2c_error;
  logic       init_done;
  logic       err_sticky;

  pcf8574_lcd_seq #(
    .ADDR(7'h27),
    .BACKLIGHT(1'b1),
    .INIT_WAIT_CYCLES(10),
    .SETTLE_CYCLES(SETTLE),
    .START_TIMEOUT(4),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs(in_rs),
    .in_data(in_data),
    .i2c_addr(i2c_addr),
    .i2c_data(i2c_data),
    .i2c_write_ena(i2c_write_ena),
    .i2c_busy(i2c_busy),
    .i2c_error(i2c_error),
    .init_done(init_done),
    .err_sticky(err_sticky)
  );

  typedef struct {
    logic [7:0] data;
    int         kind;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         exp_sticky = 1'b0;
  logic [7:0] drv_eb = 8'h00;
  int         drv_left = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // PCF8574 byte from the LCD wiring: D7..D4 on P7..P4, BL=P3, EN=P2, RW=P1, RS=P0.
  function automatic logic [7:0] port_byte(input int nib, input int en, input int rs);
    return 8'(nib * 16 + BL * 8 + en * 4 + rs);
  endfunction

  task automatic push_init();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = port_byte((i < 6) ? 3 : 2, (i % 2 == 0) ? 1 : 0, 0);
      e.kind = (i == 0) ? K_IFIRST : K_NORMAL;
      q.push_back(e);
    end
  endtask

  function automatic logic [7:0] txn_byte(input int rs, input int d, input int k);
    int nib;
    nib = (k < 2) ? (d / 16) : (d % 16);
    return port_byte(nib, (k % 2 == 0) ? 1 : 0, rs);
  endfunction

  // Expected pulses for one LCD byte, including retries caused by the error plan.
  task automatic push_txn(input int rs, input int d, input logic [7:0] eb, input int ecnt);
    exp_t e;
    int   left;
    int   n;
    left = ecnt;
    for (int k = 0; k < 4; k++) begin
      e.data = txn_byte(rs, d, k);
      n = 0;
      while (1) begin
        e.kind = (n > 0) ? K_RETRY : ((k == 0) ? K_UFIRST : K_NORMAL);
        q.push_back(e);
        n++;
        if (e.data == eb && left > 0) begin
          left--;
          if (n > MAXR) begin
            exp_sticky = 1'b1;
            break;
          end
        end else begin
          break;
        end
      end
    end
    drv_eb   = eb;
    drv_left = ecnt;
  endtask

  // Writer model: busy 2 cycles after the pulse, held 5 cycles; error shown from the fall.
  initial begin
    int t;
    bit cur_err;
    t = 100;
    cur_err = 1'b0;
    i2c_busy = 1'b0;
    i2c_error = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        t = 100;
        i2c_busy = 1'b0;
        i2c_error = 1'b0;
      end else begin
        if (i2c_write_ena) begin
          t = 0;
          i2c_error = 1'b0;
          cur_err = (i2c_data == drv_eb) && (drv_left > 0);
          if (cur_err) drv_left--;
        end else if (t < 100) begin
          t++;
        end
        i2c_busy = (t >= 2 && t <= 6);
        if (t == 7) i2c_error = cur_err;
      end
    end
  end

  // Monitor: pops one expected byte per write pulse and checks surrounding timing.
  initial begin
    exp_t e;
    int   last_fall;
    int   acc_cyc;
    bit   last_busy;
    bit   last_we;
    bit   last_id;
    bit   last_ir;
    last_fall = -1000;
    acc_cyc = -1000;
    last_busy = 1'b0;
    last_we = 1'b0;
    last_id = 1'b0;
    last_ir = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_fall = -1000;
        acc_cyc = -1000;
        last_busy = 1'b0;
        last_we = 1'b0;
        last_id = 1'b0;
        last_ir = 1'b0;
      end else begin
        if (in_valid && in_ready) acc_cyc = cyc;
        if (last_busy && !i2c_busy) last_fall = cyc;
        if (i2c_write_ena) begin
          check("pulse_while_busy", 32'(i2c_busy), 32'd0);
          check("pulse_width", 32'(last_we), 32'd0);
          check("in_ready_during_txn", 32'(in_ready), 32'd0);
          check("i2c_addr", 32'(i2c_addr), 32'h27);
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: got data 0x%0h, expected no pulse (cycle %0d)", i2c_data, cyc);
          end else begin
            e = q.pop_front();
            check("i2c_data", 32'(i2c_data), 32'(e.data));
            case (e.kind)
              K_UFIRST: check("accept_latency", 32'(cyc - acc_cyc), 32'd3);
              K_RETRY:  check("retry_gap", 32'(cyc - last_fall - 1), 32'd1);
              K_NORMAL: check("settle_gap", 32'(cyc - last_fall - 1), 32'd5);
              default: ;
            endcase
          end
        end
        if (init_done && !last_id) check("init_done_time", 32'(cyc - last_fall), 32'(1 + SETTLE));
        if (in_ready && !last_ir) begin
          check("in_ready_time", 32'(cyc - last_fall), 32'(2 + SETTLE));
          check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
        end
        last_busy = i2c_busy;
        last_we = i2c_write_ena;
        last_id = init_done;
        last_ir = in_ready;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_write_ena"}, 32'(i2c_write_ena), 32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd0);
    check({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, "_i2c_data"}, 32'(i2c_data), 32'h08);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) timeout_fail(name);
  endtask

  // Hold in_valid until accepted, then wait for the sequencer to return to idle.
  task automatic drive_and_finish(input int rs, input int d, input bit wait_idle);
    int n;
    @(posedge clk);
    #1;
    in_rs = rs[0];
    in_data = 8'(d);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) timeout_fail("accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (wait_idle) wait_ready("txn_done");
  endtask

  task automatic send(input int rs, input int d, input logic [7:0] eb, input int ecnt);
    wait_ready("ready_before_send");
    push_txn(rs, d, eb, ecnt);
    drive_and_finish(rs, d, 1'b1);
  endtask

  initial begin
    int rs;
    int d;
    int n;
    logic [7:0] eb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_rs = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    check("por_i2c_addr", 32'(i2c_addr), 32'h27);
    rst_n = 1'b1;
    push_init();

    // Byte offered during init must wait until in_ready.
    push_txn(1, 8'h41, 8'h00, 0);
    drive_and_finish(1, 8'h41, 1'b1);
    check("init_done_held", 32'(init_done), 32'd1);

    send(0, 8'h01, 8'h00, 0);
    send(1, 8'h41, 8'h4D, 1);
    send(0, 8'h01, 8'h1C, 100);

    for (int i = 0; i < 8; i++) begin
      rs = int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 255));
      eb = txn_byte(rs, d, int'($urandom_range(0, 3)));
      send(rs, d, eb, int'($urandom_range(0, 3)));
    end

    // Reset while a user byte is in WAIT_DONE.
    wait_ready("ready_before_reset_txn");
    push_txn(1, 8'h55, 8'h00, 0);
    drive_and_finish(1, 8'h55, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q.size() == 2 && i2c_busy) && n < 500);
    if (!(q.size() == 2 && i2c_busy)) timeout_fail("reach_wait_done");
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    exp_sticky = 1'b0;
    drv_left = 0;
    #1;
    check_reset_vals("mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_init();
    wait_ready("reinit_done");

    send(0, 8'h28, 8'h00, 0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
